spi_slave_if: RTL and testbench
===============================

// Module: spi_slave_if
// PURPOSE
//  SPI slave front-end feeding the single-port RAM. Deserialises MOSI frames
//  (2-bit command + DATA_W payload) into rx_data/rx_valid.
//  Serialises the RAM read word (tx_data/tx_valid) back out on MISO.
//  Clocked directly by the SPI serial clock. SPI mode 0: sample and drive on posedge clk.
// PARAMETERS
//  DATA_W   8   RAM word/address width; frame width FRAME_W = DATA_W+2
// PORTS
//  clk       in   1        SPI serial clock; sole clock of the block
//  rst       in   1        reset, asynchronous, active-high
//  SS_n      in   1        slave select, active-low, frames a transaction
//  MOSI      in   1        serial data in, MSB first
//  MISO      out  1        serial data out, MSB first
//  rx_data   out  FRAME_W  {cmd[1:0], payload} to RAM din
//  rx_valid  out  1        1-cycle strobe, rx_data valid
//  tx_data   in   DATA_W   read word from RAM dout
//  tx_valid  in   1        tx_data valid (RAM pulses after cmd 2'b11)
// BEHAVIOUR
//  Reset values: MISO=0, rx_data=0, rx_valid=0, state=IDLE, bit_cnt=0, rd_addr_done=0.
//  States:
//  IDLE: SS_n=0 -> CHK_CMD.
//  CHK_CMD: samples MOSI as frame bit FRAME_W-1 (shifted in).
//    MOSI=0 -> WRITE.
//    MOSI=1 & !rd_addr_done -> READ_ADD.
//    MOSI=1 & rd_addr_done -> READ_DATA.
//  WRITE/READ_ADD: shift 9 further MOSI bits.
//    After 10th bit: rx_data<=shifter and rx_valid=1 for exactly one cycle
//    (the cycle after the last bit sample). Then hold in the same state until SS_n=1.
//  READ_ADD completion sets rd_addr_done. READ_DATA completion clears it.
//  READ_DATA:
//    Receive 10 bits as above (rx_valid pulse).
//    Wait for tx_valid. Latch tx_data on the tx_valid cycle.
//    Drive MISO = tx_data[DATA_W-1] on the next cycle, then one bit per cycle
//    down to bit 0 (DATA_W cycles).
//    Then MISO=0 and hold until SS_n=1.
//  Extra MOSI bits after the 10th are ignored. No second rx_valid in the same frame.
//  SS_n=1 in any state: next cycle IDLE. bit_cnt and shifter are cleared.
//    A partial frame produces no rx_valid.
//    An aborted READ_DATA drive stops; MISO=0.
//    rd_addr_done is unchanged on abort.
//  rst asserted mid-frame: all registers return to reset values immediately.
//    rx_valid drops asynchronously.
//  tx_valid outside READ_DATA wait: ignored.
//  tx_valid and SS_n=1 in the same cycle: SS_n wins; no MISO output.
//  MISO is 0 whenever not serialising.
//  The payload bits and cmd[0] are not interpreted here; the RAM decodes them.
// STRUCTURE
//  Package spi_ram_pkg:
//    state enum IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA
//    cmd localparams CMD_WR_ADDR=2'b00, CMD_WR_DATA=2'b01,
//      CMD_RD_ADDR=2'b10, CMD_RD_DATA=2'b11
//    DATA_W default
//  Sub-module spi_tx_serializer: load on tx_valid, DATA_W-bit shift out,
//    busy/done flags.
//  The FSM and RX shifter live in the top module.
// TESTING
//  1. Reset state: rst=1 -> MISO=0, rx_valid=0, rx_data=0.
//  2. Write-address frame:
//     SS_n=0, shift 00_1010_0101 -> single rx_valid with rx_data=10'h0A5.
//  3. Write-data frame: shift 01_0011_1100 -> rx_data=10'h13C, one pulse.
//     Then SS_n=1 -> IDLE.
//  4. Read pair:
//     First frame 10_1010_0101 -> rx_data=10'h2A5, rd_addr_done=1.
//     Next frame 11_xxxxxxxx -> rx_data[9:8]=11.
//     Model tx_valid one cycle later with tx_data=8'hC3 -> MISO 1,1,0,0,0,0,1,1
//     on the following 8 cycles; rd_addr_done=0.
//  5. Abort: SS_n=1 after 6 bits -> no rx_valid. The next full frame decodes correctly.
//  6. Reset mid-frame:
//     Assert rst during bit 4 of a write frame, and again during MISO bit 3
//     of a read -> outputs reset asynchronously. The next frame is correct.

Source files
------------

// File: rtl/spi_slave_if_pkg.sv
// Shared types and constants for the SPI slave front-end of the single-port RAM.
// The frame is a 2-bit command followed by a DATA_W-bit payload, MSB first.
package spi_ram_pkg;

  localparam int DATA_W_DEF = 8;

  typedef enum logic [2:0] {
    IDLE,
    CHK_CMD,
    WRITE,
    READ_ADD,
    READ_DATA
  } state_t;

  localparam logic [1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [1:0] CMD_WR_DATA = 2'b01;
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;

  function automatic int frame_w(input int dw);
    return dw + 2;
  endfunction

endpackage

// File: rtl/spi_slave_if_if.sv
// Bundle of the SPI pins and the RAM-side rx/tx handshake.
// The slave modport is the front-end's view; master is the SPI host plus RAM.
interface spi_slave_if_if
  import spi_ram_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
);

  localparam int FRAME_W = DATA_W + 2;

  logic               SS_n;
  logic               MOSI;
  logic               MISO;
  logic [FRAME_W-1:0] rx_data;
  logic               rx_valid;
  logic [DATA_W-1:0]  tx_data;
  logic               tx_valid;

  modport slave (
    input  SS_n,
    input  MOSI,
    input  tx_data,
    input  tx_valid,
    output MISO,
    output rx_data,
    output rx_valid
  );

  modport master (
    output SS_n,
    output MOSI,
    output tx_data,
    output tx_valid,
    input  MISO,
    input  rx_data,
    input  rx_valid
  );

endinterface

// File: rtl/spi_slave_if_tx.sv
// MISO serializer: loads a RAM read word and shifts it out MSB first, one bit
// per clock. done stays set after the last bit until the next clear or load.
module spi_tx_serializer
#(
  parameter int DATA_W = 8
)
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              load,
  input  logic [DATA_W-1:0] din,
  output logic              miso,
  output logic              busy,
  output logic              done
);

  localparam int CNT_W = (DATA_W > 2) ? $clog2(DATA_W) : 1;

  logic [DATA_W-1:0] shift_reg;
  logic [DATA_W-1:0] shift_src;
  logic [DATA_W-1:0] shift_next;
  logic [CNT_W-1:0]  cnt_reg;
  logic              miso_reg;
  logic              busy_reg;
  logic              done_reg;
  logic              step;

  // A fresh load shifts straight from din so bit DATA_W-1 appears on the
  // cycle right after the load edge.
  assign shift_src = load ? din : shift_reg;
  assign step      = load || (busy_reg && (cnt_reg != '0));

  generate
    for (genvar gi = 0; gi < DATA_W; gi++) begin : g_shift
      if (gi == 0) begin : g_lsb
        assign shift_next[gi] = 1'b0;
      end else begin : g_bit
        assign shift_next[gi] = shift_src[gi-1];
      end
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_reg <= '0;
      cnt_reg   <= '0;
      miso_reg  <= 1'b0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else if (clr) begin
      shift_reg <= '0;
      cnt_reg   <= '0;
      miso_reg  <= 1'b0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else if (step) begin
      miso_reg  <= shift_src[DATA_W-1];
      shift_reg <= shift_next;
      cnt_reg   <= load ? CNT_W'(DATA_W - 1) : cnt_reg - 1'b1;
      busy_reg  <= 1'b1;
      done_reg  <= 1'b0;
    end else if (busy_reg) begin
      miso_reg  <= 1'b0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b1;
    end
  end

  assign miso = miso_reg;
  assign busy = busy_reg;
  assign done = done_reg;

endmodule

// File: rtl/spi_slave_if.sv
// SPI mode-0 slave front-end: deserialises command frames for the RAM and
// serialises the RAM read word back on MISO. Runs on the SPI clock itself.
module spi_slave_if
  import spi_ram_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
)
(
  input  logic          clk,
  input  logic          rst,
  spi_slave_if_if.slave bus
);

  localparam int FRAME_W = frame_w(DATA_W);
  localparam int CNT_W   = $clog2(FRAME_W + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_W - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FRAME_W);

  state_t             state_reg;
  state_t             state_next;
  logic [CNT_W-1:0]   bit_cnt_reg;
  logic [FRAME_W-2:0] shift_reg;
  logic [FRAME_W-1:0] frame_word;
  logic [FRAME_W-1:0] rx_data_reg;
  logic               rx_valid_reg;
  logic               rd_addr_done_reg;

  logic in_body;
  logic shift_en;
  logic frame_done;
  logic set_rd;
  logic clr_rd;
  logic ser_load;
  logic ser_clr;
  logic ser_miso;
  logic ser_busy;
  logic ser_done;

  assign frame_word = {shift_reg, bus.MOSI};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (!bus.SS_n) state_next = CHK_CMD;
      end
      CHK_CMD: begin
        if (bus.SS_n)                          state_next = IDLE;
        else if (bus.MOSI == CMD_WR_ADDR[1])   state_next = WRITE;
        else if (rd_addr_done_reg)             state_next = READ_DATA;
        else                                   state_next = READ_ADD;
      end
      WRITE, READ_ADD, READ_DATA: begin
        if (bus.SS_n) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Once bit_cnt reaches FULL_CNT the frame is closed: later MOSI bits are
  // ignored and no second rx_valid can fire until SS_n rises.
  always_comb begin
    in_body    = (state_reg == WRITE) || (state_reg == READ_ADD) ||
                 (state_reg == READ_DATA);
    shift_en   = !bus.SS_n &&
                 ((state_reg == CHK_CMD) || (in_body && (bit_cnt_reg < FULL_CNT)));
    frame_done = !bus.SS_n && in_body && (bit_cnt_reg == LAST_BIT);
    set_rd     = frame_done && (state_reg == READ_ADD);
    clr_rd     = frame_done && (state_reg == READ_DATA);
    ser_load   = !bus.SS_n && (state_reg == READ_DATA) &&
                 (bit_cnt_reg == FULL_CNT) && !ser_busy && !ser_done &&
                 bus.tx_valid;
    ser_clr    = bus.SS_n;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_cnt_reg      <= '0;
      shift_reg        <= '0;
      rx_data_reg      <= '0;
      rx_valid_reg     <= 1'b0;
      rd_addr_done_reg <= 1'b0;
    end else begin
      rx_valid_reg <= frame_done;
      if (frame_done) rx_data_reg <= frame_word;
      if (set_rd) rd_addr_done_reg <= 1'b1;
      else if (clr_rd) rd_addr_done_reg <= 1'b0;
      if (bus.SS_n) begin
        bit_cnt_reg <= '0;
        shift_reg   <= '0;
      end else if (shift_en) begin
        bit_cnt_reg <= bit_cnt_reg + 1'b1;
        shift_reg   <= frame_word[FRAME_W-2:0];
      end
    end
  end

  spi_tx_serializer #(
    .DATA_W (DATA_W)
  ) u_tx (
    .clk  (clk),
    .rst  (rst),
    .clr  (ser_clr),
    .load (ser_load),
    .din  (bus.tx_data),
    .miso (ser_miso),
    .busy (ser_busy),
    .done (ser_done)
  );

  assign bus.MISO     = ser_miso;
  assign bus.rx_data  = rx_data_reg;
  assign bus.rx_valid = rx_valid_reg;

endmodule

// File: tb/tb_spi_slave_if.sv
// Directed frames for the SPI slave front-end with a queue-based scoreboard
// for rx words and MISO read words.
module tb_spi_slave_if;
  import spi_ram_pkg::*;

  localparam int DW = 8;
  localparam int FW = DW + 2;

  logic clk = 1'b0;
  logic rst;

  spi_slave_if_if #(.DATA_W(DW)) bus ();

  spi_slave_if #(.DATA_W(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [FW-1:0] rx_q[$];
  logic [DW-1:0] miso_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Monitor: samples 1 time unit after each rising edge.
  logic          tv_s;
  logic          cap_act = 1'b0;
  int            cap_n   = 0;
  logic [DW-1:0] cap_word;
  logic [DW-1:0] cap_exp;
  logic [FW-1:0] rx_exp;

  always begin
    @(posedge clk);
    tv_s = bus.tx_valid & ~bus.SS_n;
    #1;
    if (!rst && bus.rx_valid === 1'b1) begin
      checks++;
      if (rx_q.size() == 0) begin
        errors++;
        $display("FAIL rx_unexpected actual=%h required=no_pulse", bus.rx_data);
      end else begin
        rx_exp = rx_q.pop_front();
        if (bus.rx_data !== rx_exp) begin
          errors++;
          $display("FAIL rx_data actual=%h required=%h", bus.rx_data, rx_exp);
        end else begin
          $display("RX   rx_data=%h ok", bus.rx_data);
        end
      end
    end
    if (rst || bus.SS_n) cap_act = 1'b0;
    if (!cap_act && tv_s && miso_q.size() > 0) begin
      cap_exp = miso_q.pop_front();
      cap_act = 1'b1;
      cap_n   = 0;
    end
    if (cap_act) begin
      cap_word = {cap_word[DW-2:0], bus.MISO};
      cap_n++;
      if (cap_n == DW) begin
        cap_act = 1'b0;
        chk("miso_word", 32'(cap_word), 32'(cap_exp));
        $display("TX   miso_word=%h expected=%h", cap_word, cap_exp);
      end
    end else begin
      chk("miso_idle", 32'(bus.MISO), 32'd0);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic start_frame();
    @(negedge clk);
    bus.SS_n = 1'b0;
    bus.MOSI = 1'b0;
  endtask

  task automatic shift_bits(input logic [FW-1:0] f, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      @(negedge clk);
      bus.MOSI = f[FW-1-i];
    end
  endtask

  task automatic end_frame(input int tail);
    for (int i = 0; i < tail; i++) begin
      @(negedge clk);
      bus.MOSI = 1'($urandom);
    end
    @(negedge clk);
    bus.SS_n = 1'b1;
    bus.MOSI = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_frame(input logic [FW-1:0] f, input bit tx_pulse,
                          input logic [DW-1:0] txw, input bit expect_tx, input int tail);
    start_frame();
    rx_q.push_back(f);
    shift_bits(f, FW);
    if (tx_pulse) begin
      @(negedge clk);
      bus.tx_valid = 1'b1;
      bus.tx_data  = txw;
      if (expect_tx) miso_q.push_back(txw);
      @(negedge clk);
      bus.tx_valid = 1'b0;
    end
    end_frame(tail);
    $display("FRM  frame=%h sent", f);
  endtask

  initial begin
    rst          = 1'b1;
    bus.SS_n     = 1'b1;
    bus.MOSI     = 1'b0;
    bus.tx_valid = 1'b0;
    bus.tx_data  = '0;
    repeat (2) @(negedge clk);
    chk("reset_miso", 32'(bus.MISO), 32'd0);
    chk("reset_rx_valid", 32'(bus.rx_valid), 32'd0);
    chk("reset_rx_data", 32'(bus.rx_data), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Write address, then write data with extra trailing bits.
    do_frame({CMD_WR_ADDR, 8'hA5}, 1'b0, 8'h00, 1'b0, 3);
    do_frame(10'h13C, 1'b0, 8'h00, 1'b0, 4);

    // Read address: a stray tx_valid here must not drive MISO.
    do_frame(10'h2A5, 1'b1, 8'hFF, 1'b0, 4);
    // Read data: RAM answers one cycle after rx_valid.
    do_frame({CMD_RD_DATA, 8'h77}, 1'b1, 8'hC3, 1'b1, 10);

    // tx_valid coinciding with SS_n rising: no MISO output.
    do_frame({CMD_RD_ADDR, 8'h11}, 1'b0, 8'h00, 1'b0, 0);
    start_frame();
    rx_q.push_back(10'h322);
    shift_bits(10'h322, FW);
    @(negedge clk);
    bus.tx_valid = 1'b1;
    bus.tx_data  = 8'hFF;
    bus.SS_n     = 1'b1;
    @(negedge clk);
    bus.tx_valid = 1'b0;
    @(negedge clk);
    $display("FRM  frame=322 closed with tx_valid");

    // Abort after 6 bits, then a full frame.
    start_frame();
    shift_bits(10'h3FF, 6);
    end_frame(0);
    $display("FRM  partial frame aborted");
    do_frame({CMD_WR_DATA, 8'h5A} & 10'h0FF, 1'b0, 8'h00, 1'b0, 2);

    // Reset during bit 4 of a write frame.
    start_frame();
    shift_bits(10'h1F0, 4);
    @(negedge clk);
    rst      = 1'b1;
    bus.SS_n = 1'b1;
    #1;
    chk("rst_wr_rx_valid", 32'(bus.rx_valid), 32'd0);
    chk("rst_wr_rx_data", 32'(bus.rx_data), 32'd0);
    chk("rst_wr_miso", 32'(bus.MISO), 32'd0);
    $display("RST  mid write frame");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    do_frame(10'h1F0, 1'b0, 8'h00, 1'b0, 1);

    // Reset during MISO bit 3 of a read (5A has bit 3 set).
    do_frame(10'h201, 1'b0, 8'h00, 1'b0, 0);
    start_frame();
    rx_q.push_back(10'h302);
    shift_bits(10'h302, FW);
    @(negedge clk);
    bus.tx_valid = 1'b1;
    bus.tx_data  = 8'h5A;
    miso_q.push_back(8'h5A);
    @(negedge clk);
    bus.tx_valid = 1'b0;
    repeat (4) @(negedge clk);
    rst      = 1'b1;
    bus.SS_n = 1'b1;
    #1;
    chk("rst_rd_miso", 32'(bus.MISO), 32'd0);
    chk("rst_rd_rx_data", 32'(bus.rx_data), 32'd0);
    chk("rst_rd_rx_valid", 32'(bus.rx_valid), 32'd0);
    $display("RST  mid read drive");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    do_frame(10'h0C3, 1'b0, 8'h00, 1'b0, 2);

    repeat (5) @(negedge clk);
    chk("rx_q_drained", 32'(rx_q.size()), 32'd0);
    chk("miso_q_drained", 32'(miso_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
